// File: rtl/perm_pkg.sv
// Shared constants and the stride-4 source-index helper for the 64-point
// permutation engine.
package perm_pkg;

  localparam int WIDTH   = 18;
  localparam int LANES   = 32;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 5;
  localparam int CPLX    = LANES / 2;
  localparam int CW      = $clog2(DEPTH);
  localparam int MW      = $clog2(CPLX);

  // Output (c', m') carries k = DEPTH*m' + c'. With power-of-two sizes that is
  // {m', c'}: the upper CW bits are the source vector, the lower MW bits the source lane.
  function automatic logic [CW+MW-1:0] src_index(input logic [CW-1:0] c_out,
                                                 input logic [MW-1:0] m_out);
    return {m_out, c_out};
  endfunction

endpackage

// File: rtl/perm_bank.sv
// One frame of DEPTH x LANES words: a whole vector is written per cycle, and
// the read port returns one output vector already in stride-permuted order.
module perm_bank #(
  parameter int WIDTH = perm_pkg::WIDTH,
  parameter int LANES = perm_pkg::LANES,
  parameter int DEPTH = perm_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [LANES*WIDTH-1:0]     wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [LANES*WIDTH-1:0]     rd_data
);
  import perm_pkg::*;

  logic [LANES-1:0][WIDTH-1:0] mem [DEPTH];
  logic [LANES-1:0][WIDTH-1:0] rd_lanes;

  // Frame storage carries no reset; the read side never exposes an unwritten frame.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  for (genvar mo = 0; mo < CPLX; mo++) begin : g_rd
    logic [CW+MW-1:0] src;
    assign src              = src_index(rd_idx, MW'(mo));
    assign rd_lanes[2*mo]   = mem[src[CW+MW-1:MW]][{src[MW-1:0], 1'b0}];
    assign rd_lanes[2*mo+1] = mem[src[CW+MW-1:MW]][{src[MW-1:0], 1'b1}];
  end

  assign rd_data = rd_lanes;

endmodule

// File: rtl/stride_perm_32x4.sv
// Stride-4 permutation of 64-point complex frames, 32 words per cycle, ping-pong banks.
// Optional macro PERM_OVERRUN_DET_EN: ignore early frame starts and flag them on overrun.
module stride_perm_32x4 #(
  parameter int WIDTH = perm_pkg::WIDTH,
  parameter int LANES = perm_pkg::LANES,
  parameter int DEPTH = perm_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next_in,
  input  logic [WIDTH-1:0] X0_in,  X1_in,  X2_in,  X3_in,  X4_in,  X5_in,  X6_in,  X7_in,
  input  logic [WIDTH-1:0] X8_in,  X9_in,  X10_in, X11_in, X12_in, X13_in, X14_in, X15_in,
  input  logic [WIDTH-1:0] X16_in, X17_in, X18_in, X19_in, X20_in, X21_in, X22_in, X23_in,
  input  logic [WIDTH-1:0] X24_in, X25_in, X26_in, X27_in, X28_in, X29_in, X30_in, X31_in,
  output logic [WIDTH-1:0] Y0,  Y1,  Y2,  Y3,  Y4,  Y5,  Y6,  Y7,
  output logic [WIDTH-1:0] Y8,  Y9,  Y10, Y11, Y12, Y13, Y14, Y15,
  output logic [WIDTH-1:0] Y16, Y17, Y18, Y19, Y20, Y21, Y22, Y23,
  output logic [WIDTH-1:0] Y24, Y25, Y26, Y27, Y28, Y29, Y30, Y31,
  output logic             next_out,
  output logic             overrun
);
  import perm_pkg::*;

  logic [LANES*WIDTH-1:0] x_bus, y_q, rd_data0, rd_data1;
  logic [CW-1:0]          wr_cnt, rd_cnt;
  logic                   wr_active, rd_active, bank_sel, next_out_q;
  logic                   frame_done, restart;

  assign x_bus = {X31_in, X30_in, X29_in, X28_in, X27_in, X26_in, X25_in, X24_in,
                  X23_in, X22_in, X21_in, X20_in, X19_in, X18_in, X17_in, X16_in,
                  X15_in, X14_in, X13_in, X12_in, X11_in, X10_in, X9_in,  X8_in,
                  X7_in,  X6_in,  X5_in,  X4_in,  X3_in,  X2_in,  X1_in,  X0_in};

  assign {Y31, Y30, Y29, Y28, Y27, Y26, Y25, Y24,
          Y23, Y22, Y21, Y20, Y19, Y18, Y17, Y16,
          Y15, Y14, Y13, Y12, Y11, Y10, Y9,  Y8,
          Y7,  Y6,  Y5,  Y4,  Y3,  Y2,  Y1,  Y0} = y_q;

  assign next_out   = next_out_q;
  assign frame_done = wr_active && (wr_cnt == CW'(DEPTH-1));

`ifdef PERM_OVERRUN_DET_EN
  logic early, overrun_q;
  // A start is early while a frame is still being captured; the last input cycle is fine.
  assign early   = next_in && wr_active && !frame_done;
  assign restart = next_in && !early;
  assign overrun = overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     overrun_q <= 1'b0;
    else if (early) overrun_q <= 1'b1;
  end
`else
  // An early start simply restarts capture; the partial frame never completes.
  assign restart = next_in;
  assign overrun = 1'b0;
`endif

  // Capture stage: write counter, bank swap at frame end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_active  <= 1'b0;
      wr_cnt     <= '0;
      bank_sel   <= 1'b0;
      next_out_q <= 1'b0;
    end else begin
      if (restart) begin
        wr_active <= 1'b1;
        wr_cnt    <= '0;
      end else if (wr_active) begin
        wr_cnt <= wr_cnt + CW'(1);
        if (frame_done) wr_active <= 1'b0;
      end
      bank_sel   <= bank_sel ^ frame_done;
      next_out_q <= frame_done;
    end
  end

  // Readout stage: read counter walks the bank that was just filled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_active <= 1'b0;
      rd_cnt    <= '0;
      y_q       <= '0;
    end else begin
      if (frame_done) begin
        rd_active <= 1'b1;
        rd_cnt    <= '0;
      end else if (rd_active) begin
        rd_cnt <= rd_cnt + CW'(1);
        if (rd_cnt == CW'(DEPTH-1)) rd_active <= 1'b0;
      end
      if (rd_active) y_q <= bank_sel ? rd_data0 : rd_data1;
    end
  end

  perm_bank #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_active && !bank_sel),
    .wr_idx  (wr_cnt),
    .wr_data (x_bus),
    .rd_idx  (rd_cnt),
    .rd_data (rd_data0)
  );

  perm_bank #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_active && bank_sel),
    .wr_idx  (wr_cnt),
    .wr_data (x_bus),
    .rd_idx  (rd_cnt),
    .rd_data (rd_data1)
  );

endmodule

// File: tb/tb_stride_perm_32x4.sv
// Directed, table-driven bench for stride_perm_32x4 (either PERM_OVERRUN_DET_EN build).
module tb_stride_perm_32x4;

  logic        clk = 1'b0;
  logic        reset;
  logic        next_in;
  logic        next_out;
  logic        overrun;
  logic [17:0] x [32];
  logic [17:0] y [32];

  always #5 clk = ~clk;

  stride_perm_32x4 dut (
    .clk(clk), .reset(reset), .next_in(next_in),
    .X0_in(x[0]),   .X1_in(x[1]),   .X2_in(x[2]),   .X3_in(x[3]),
    .X4_in(x[4]),   .X5_in(x[5]),   .X6_in(x[6]),   .X7_in(x[7]),
    .X8_in(x[8]),   .X9_in(x[9]),   .X10_in(x[10]), .X11_in(x[11]),
    .X12_in(x[12]), .X13_in(x[13]), .X14_in(x[14]), .X15_in(x[15]),
    .X16_in(x[16]), .X17_in(x[17]), .X18_in(x[18]), .X19_in(x[19]),
    .X20_in(x[20]), .X21_in(x[21]), .X22_in(x[22]), .X23_in(x[23]),
    .X24_in(x[24]), .X25_in(x[25]), .X26_in(x[26]), .X27_in(x[27]),
    .X28_in(x[28]), .X29_in(x[29]), .X30_in(x[30]), .X31_in(x[31]),
    .Y0(y[0]),   .Y1(y[1]),   .Y2(y[2]),   .Y3(y[3]),
    .Y4(y[4]),   .Y5(y[5]),   .Y6(y[6]),   .Y7(y[7]),
    .Y8(y[8]),   .Y9(y[9]),   .Y10(y[10]), .Y11(y[11]),
    .Y12(y[12]), .Y13(y[13]), .Y14(y[14]), .Y15(y[15]),
    .Y16(y[16]), .Y17(y[17]), .Y18(y[18]), .Y19(y[19]),
    .Y20(y[20]), .Y21(y[21]), .Y22(y[22]), .Y23(y[23]),
    .Y24(y[24]), .Y25(y[25]), .Y26(y[26]), .Y27(y[27]),
    .Y28(y[28]), .Y29(y[29]), .Y30(y[30]), .Y31(y[31]),
    .next_out(next_out), .overrun(overrun)
  );

  typedef struct {
    int ocyc;
    int lane;
    int exp;
  } vec_t;

  vec_t tbl [13];
  int   total  = 0;
  int   passed = 0;

  int   nin  [40];
  int   xf   [40];
  int   xc   [40];
  int   nlog [40];
  int   olog [40];
  int   ylog [40][32];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Frame pattern: even word of lane m, vector c = seed*0x1000 + 16c+m; odd word adds 0x100.
  function automatic logic [17:0] gen(input int seed, input int c, input int lane);
    int v;
    if (seed == 99) return 18'h20000;
    v = (seed << 12) + ((lane % 2) * 'h100) + 16 * c + lane / 2;
    return v[17:0];
  endfunction

  task automatic clear_sched();
    for (int t = 0; t < 40; t++) begin
      nin[t] = 0;
      xf[t]  = -1;
      xc[t]  = 0;
    end
  endtask

  task automatic set_frame(input int t0, input int seed);
    nin[t0] = 1;
    for (int c = 0; c < 4; c++) begin
      xf[t0 + 1 + c] = seed;
      xc[t0 + 1 + c] = c;
    end
  endtask

  // Each iteration: record outputs of cycle t, then drive inputs for cycle t.
  task automatic run(input int n);
    for (int t = 0; t < n; t++) begin
      nlog[t] = int'(next_out);
      olog[t] = int'(overrun);
      for (int l = 0; l < 32; l++) ylog[t][l] = int'(y[l]);
      next_in = nin[t][0];
      for (int l = 0; l < 32; l++) x[l] = (xf[t] >= 0) ? gen(xf[t], xc[t], l) : 18'h0;
      @(posedge clk);
      #1;
    end
    next_in = 1'b0;
    for (int l = 0; l < 32; l++) x[l] = 18'h0;
  endtask

  task automatic chk_nout(input string name, input int n, input int e1, input int e2, input int e3);
    for (int t = 0; t < n; t++)
      chk($sformatf("%s t=%0d", name, t), nlog[t], int'(t == e1 || t == e2 || t == e3));
  endtask

  task automatic chk_frame(input string name, input int t0, input int seed);
    for (int i = 0; i < 13; i++)
      chk($sformatf("%s c'=%0d Y%0d", name, tbl[i].ocyc, tbl[i].lane),
          ylog[t0 + tbl[i].ocyc][tbl[i].lane], tbl[i].exp + (seed << 12));
  endtask

  initial begin
    // Hand-derived: Y(2m') at cycle c' = 4m'+c', Y(2m'+1) adds 0x100.
    tbl[0]  = '{0, 0,  'h000};
    tbl[1]  = '{0, 2,  'h004};
    tbl[2]  = '{0, 4,  'h008};
    tbl[3]  = '{0, 30, 'h03C};
    tbl[4]  = '{0, 1,  'h100};
    tbl[5]  = '{1, 0,  'h001};
    tbl[6]  = '{1, 6,  'h00D};
    tbl[7]  = '{1, 17, 'h121};
    tbl[8]  = '{2, 31, 'h13E};
    tbl[9]  = '{3, 0,  'h003};
    tbl[10] = '{3, 2,  'h007};
    tbl[11] = '{3, 30, 'h03F};
    tbl[12] = '{3, 31, 'h13F};

    reset   = 1'b0;
    next_in = 1'b0;
    for (int l = 0; l < 32; l++) x[l] = 18'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset Y0", int'(y[0]), 0);
    chk("reset Y31", int'(y[31]), 0);
    chk("reset next_out", int'(next_out), 0);
    chk("reset overrun", int'(overrun), 0);
    reset = 1'b1;

    // Single frame right after reset release
    clear_sched();
    set_frame(0, 0);
    run(12);
    chk_nout("single next_out", 12, 5, -1, -1);
    chk_frame("single", 6, 0);
    chk("single hold Y0", ylog[11][0], 3);
    chk("single hold Y31", ylog[11][31], 'h13F);

    // Back-to-back frames at 0, 4, 8
    clear_sched();
    set_frame(0, 1);
    set_frame(4, 2);
    set_frame(8, 3);
    run(20);
    chk_nout("b2b next_out", 20, 5, 9, 13);
    chk_frame("b2b f1", 6, 1);
    chk_frame("b2b f2", 10, 2);
    chk_frame("b2b f3", 14, 3);

    // Early restart at t=2
    clear_sched();
`ifdef PERM_OVERRUN_DET_EN
    set_frame(2, 5);
    set_frame(0, 4);
    run(14);
    chk_nout("early next_out", 14, 5, -1, -1);
    chk_frame("early kept", 6, 4);
    for (int t = 0; t < 14; t++) chk($sformatf("overrun t=%0d", t), olog[t], int'(t >= 3));
`else
    set_frame(0, 4);
    set_frame(2, 5);
    run(14);
    chk_nout("early next_out", 14, 7, -1, -1);
    chk_frame("early restart", 8, 5);
    for (int t = 0; t < 14; t += 4) chk($sformatf("overrun t=%0d", t), olog[t], 0);
`endif

    // Reset mid-frame at t=3 abandons the frame
    clear_sched();
    set_frame(0, 6);
    run(3);
    reset = 1'b0;
    #1;
    chk("async reset Y0", int'(y[0]), 0);
    chk("async reset Y31", int'(y[31]), 0);
    chk("async reset overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_sched();
    run(10);
    chk_nout("after reset next_out", 10, -1, -1, -1);
    for (int t = 0; t < 10; t += 3) chk($sformatf("after reset Y0 t=%0d", t), ylog[t][0], 0);
    clear_sched();
    set_frame(0, 7);
    run(12);
    chk_nout("fresh next_out", 12, 5, -1, -1);
    chk_frame("fresh", 6, 7);

    // Negative full-scale on every lane
    clear_sched();
    set_frame(0, 99);
    run(12);
    for (int c = 0; c < 4; c++) begin
      int act;
      act = 'h20000;
      for (int l = 0; l < 32; l++)
        if (ylog[6 + c][l] != 'h20000 && act == 'h20000) act = ylog[6 + c][l];
      chk($sformatf("negfs c'=%0d", c), act, 'h20000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stride_perm_32x4.md
STRIDE_PERM_32X4 -- requirements
Module: stride_perm_32x4

Interface
REQ-001 Parameter: WIDTH, 18, word width of every data lane.
REQ-002 Parameter: LANES, 32, words per cycle; word 2m is re and 2m+1 is im of complex lane m (m = 0..15).
REQ-003 Parameter: DEPTH, 4, cycles (vectors) per frame; a frame is 64 complex points.
REQ-004 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port: reset, input, 1, asynchronous active-low reset.
REQ-006 Port: next_in, input, 1, frame-start strobe; asserted the cycle before the first input vector.
REQ-007 Port: X0_in..X31_in, input, WIDTH each, input lanes.
REQ-008 Port: Y0..Y31, output, WIDTH each, registered output lanes.
REQ-009 Port: next_out, output, 1, strobe asserted the cycle before the first output vector.
REQ-010 Port: overrun, output, 1, sticky protocol-error flag (present only when configured, REQ-026).

Function
REQ-011 If next_in=1 in cycle t, input vectors c=0..3 shall be sampled in cycles t+1..t+4.
REQ-012 Input complex index k = 16*c + m.
REQ-013 Output cycle c', complex lane m' shall carry input complex index 4*m' + c' (stride-4 permutation): source c = m' div 4, source m = 4*(m' mod 4) + c'.
REQ-014 Re and im words of a complex point shall move together, unchanged and bit-exact.
REQ-015 next_out shall pulse exactly in cycle t+5; output vectors c'=0..3 shall appear on Y in cycles t+6..t+9; latency is fixed at 5 cycles strobe-to-strobe.
REQ-016 Storage shall be two frame banks in ping-pong: the write bank fills during input cycles, and the banks swap at the end of cycle t+4.
REQ-017 Back-to-back frames: next_in shall be accepted again at t+4 at the earliest, with a new frame in t+5..t+8 and no data loss or stall.
REQ-018 next_in coinciding with the last input vector (t+4) is legal; the write/read bank swap and the new write shall not corrupt the frame being read.
REQ-019 next_in at t+1..t+3, while a frame is still being captured, is an overrun, handled per REQ-026.
REQ-020 Outside output windows, Y shall hold the last driven value.
REQ-021 A write counter (0..3, active flag) and a read counter (0..3, active flag) shall wrap 3 -> 0 and then go idle unless restarted.

Reset
REQ-022 reset=0 shall asynchronously clear next_out, Y0..Y31, both counters, active flags, the bank select and overrun to 0.
REQ-023 Bank contents are not reset; no output shall expose them until a full new frame is written.
REQ-024 Reset asserted mid-frame shall abandon both the write frame and the read frame; no next_out follows for those frames.
REQ-025 The first next_in is honoured in the first cycle after reset deasserts.

Configuration
REQ-026 Macro PERM_OVERRUN_DET_EN.
- Defined: an early next_in is ignored, the current frame completes normally, and overrun is set and held until reset.
- Undefined: an early next_in restarts the write counter at c=0 (the partial frame is discarded and its next_out is suppressed); the overrun port is tied to 0.

Structure
REQ-027 Shared package perm_pkg shall hold WIDTH, LANES, DEPTH, LATENCY=5 and the source-index function of REQ-013.
REQ-028 One sub-module, perm_bank, shall implement a single DEPTH x LANES x WIDTH register frame with a write port (vector index) and a permuted read port (output cycle index). It is instantiated twice.

Verification
REQ-029 Reset, then next_in at t=0 with X(2m) = k and X(2m+1) = 0x100+k, where k = 16c+m -> next_out at t=5 only; at t=6, Y0=0, Y2=4, Y4=8, Y30=60, Y1=0x100.
REQ-030 Same frame, check cycle t=9 -> Y0=3, Y2=7, Y30=63, Y31=0x13F.
REQ-031 Frames at t=0, 4, 8 with distinct data -> next_out at 5, 9, 13; continuous output vectors t=6..17, each frame correct.
REQ-032 With PERM_OVERRUN_DET_EN: next_in at t=0 and t=2 -> frame 0 output correct, overrun=1 from t=3 and held. Without the macro: output starts from the t=2 frame, with next_out at t=7.
REQ-033 reset pulse low at t=3 of a frame -> all outputs 0 immediately; no next_out; a fresh frame after release is correct.
REQ-034 Negative full-scale data 0x20000 on all lanes -> passes bit-exact; no sign or width alteration.
